// File: rtl/cq_slot_dispatcher_pkg.sv
// Shared types for the CQ slot dispatcher: the task payload and the commit-queue slice slot index.
package cq_slot_dispatcher_pkg;

  localparam int CQ_SLICE_SIZE = 64;

  typedef logic [$clog2(CQ_SLICE_SIZE)-1:0] cq_slice_slot_t;

  typedef struct packed {
    logic [31:0] ts;
    logic [15:0] fn;
    logic [15:0] arg;
  } task_t;

endpackage

// File: rtl/cq_slot_dispatcher_lowbit.sv
// Lowest-set-bit index finder; out is 0 when no bit is set (callers qualify with |in).
module cq_slot_dispatcher_lowbit #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 6
) (
  input  logic [IN_WIDTH-1:0]  in,
  output logic [OUT_WIDTH-1:0] out
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    out = '0;
    for (int i = IN_WIDTH - 1; i >= 0; i--) begin
      out = in[i] ? OUT_WIDTH'(i) : out;
    end
  end

endmodule

// File: rtl/cq_slot_dispatcher.sv
// Allocates the lowest free commit-queue slice slot to each accepted task and holds
// {task, slot} in a one-entry output stage for the conflict serializer.
module cq_slot_dispatcher
  import cq_slot_dispatcher_pkg::*;
#(
  parameter int CQ_SIZE = CQ_SLICE_SIZE,
  parameter int TILE_ID = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  task_t                      s_task,
  output logic                       m_valid,
  input  logic                       m_ready,
  output task_t                      m_task,
  output cq_slice_slot_t             m_cq_slot,
  input  logic                       ser_almost_full,
  input  logic                       free_valid,
  input  cq_slice_slot_t             free_slot,
  input  logic [$clog2(CQ_SIZE):0]   slot_limit,
  output logic [$clog2(CQ_SIZE):0]   slots_in_use,
  output logic                       free_error
);

  localparam int IW = $clog2(CQ_SIZE);
  localparam int CW = $clog2(CQ_SIZE) + 1;

  if (CQ_SIZE < 2 || CQ_SIZE > 2 ** $bits(cq_slice_slot_t) || TILE_ID < 0) begin : g_param_check
    $error("cq_slot_dispatcher: unsupported CQ_SIZE/TILE_ID");
  end

  logic [CQ_SIZE-1:0] slot_free_r;
  logic [CQ_SIZE-1:0] slot_free_next_s;
  logic [IW-1:0]      alloc_idx_s;
  logic               any_free_s;
  logic               under_limit_s;
  logic               ready_s;
  logic               accept_s;
  logic               free_in_range_s;
  logic               was_free_s;
  logic               free_ok_s;
  logic               free_bad_s;
  logic [CW-1:0]      in_use_r;
  logic [CW-1:0]      in_use_next_s;
  logic               m_valid_r;
  task_t              m_task_r;
  cq_slice_slot_t     m_slot_r;
  logic               free_error_r;

  cq_slot_dispatcher_lowbit #(
    .IN_WIDTH  (CQ_SIZE),
    .OUT_WIDTH (IW)
  ) u_lowbit (
    .in  (slot_free_r),
    .out (alloc_idx_s)
  );

  assign any_free_s    = |slot_free_r;
  assign under_limit_s = in_use_r < slot_limit;
  assign ready_s       = (!m_valid_r || m_ready) && any_free_s && !ser_almost_full && under_limit_s;
  assign accept_s      = s_valid && ready_s;

  // A release only counts if it names an in-range slot that is currently busy.
  assign free_in_range_s = CW'(free_slot) < CW'(CQ_SIZE);
  assign was_free_s      = free_in_range_s ? slot_free_r[free_slot] : 1'b1;
  assign free_ok_s       = free_valid && !was_free_s;
  assign free_bad_s      = free_valid && was_free_s;

  // Allocated and released slots never coincide, so each bit sees at most one event.
  always_comb begin
    slot_free_next_s = slot_free_r;
    for (int i = 0; i < CQ_SIZE; i++) begin
      slot_free_next_s[i] = (slot_free_r[i] && !(accept_s && alloc_idx_s == IW'(i)))
                          || (free_ok_s && CW'(free_slot) == CW'(i));
    end
  end

  // Net change of the in-use count from this cycle's allocate/release pair.
  always_comb begin
    in_use_next_s = in_use_r;
    case ({accept_s, free_ok_s})
      2'b10:   in_use_next_s = in_use_r + CW'(1);
      2'b01:   in_use_next_s = in_use_r - CW'(1);
      default: in_use_next_s = in_use_r;
    endcase
  end

  // Bitmap, counter, output holding register and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_free_r  <= '1;
      in_use_r     <= '0;
      m_valid_r    <= 1'b0;
      m_task_r     <= '0;
      m_slot_r     <= '0;
      free_error_r <= 1'b0;
    end else begin
      slot_free_r  <= slot_free_next_s;
      in_use_r     <= in_use_next_s;
      free_error_r <= free_error_r || free_bad_s;
      if (accept_s) begin
        m_valid_r <= 1'b1;
        m_task_r  <= s_task;
        m_slot_r  <= cq_slice_slot_t'(alloc_idx_s);
      end else if (m_ready) begin
        m_valid_r <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end
    end
  end

  assign s_ready      = ready_s;
  assign m_valid      = m_valid_r;
  assign m_task       = m_task_r;
  assign m_cq_slot    = m_slot_r;
  assign slots_in_use = in_use_r;
  assign free_error   = free_error_r;

endmodule

// File: tb/tb_cq_slot_dispatcher.sv
// Randomized and directed bench for cq_slot_dispatcher against a slot-pool reference model.
module tb_cq_slot_dispatcher;
  import cq_slot_dispatcher_pkg::*;

  localparam int N = 64;

  logic           clk = 1'b0;
  logic           rstn;
  logic           s_valid;
  logic           s_ready;
  task_t          s_task;
  logic           m_valid;
  logic           m_ready;
  task_t          m_task;
  cq_slice_slot_t m_cq_slot;
  logic           ser_almost_full;
  logic           free_valid;
  cq_slice_slot_t free_slot;
  logic [6:0]     slot_limit;
  logic [6:0]     slots_in_use;
  logic           free_error;

  cq_slot_dispatcher dut (
    .clk             (clk),
    .rstn            (rstn),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_task          (s_task),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_task          (m_task),
    .m_cq_slot       (m_cq_slot),
    .ser_almost_full (ser_almost_full),
    .free_valid      (free_valid),
    .free_slot       (free_slot),
    .slot_limit      (slot_limit),
    .slots_in_use    (slots_in_use),
    .free_error      (free_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pool of busy flags, one held entry, sticky error.
  bit          busy [N];
  bit          mdl_known = 1'b0;
  bit          mv;
  logic [63:0] mt;
  int          ms;
  bit          merr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int busy_count();
    int c = 0;
    foreach (busy[i]) c += busy[i] ? 1 : 0;
    return c;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!busy[i]) return i;
    return -1;
  endfunction

  function automatic bit model_ready();
    return (!mv || m_ready) && (busy_count() < N) && !ser_almost_full
           && (busy_count() < int'(slot_limit));
  endfunction

  // Inputs are set at the negedge; compare, advance the model, move to next negedge.
  task automatic cycle();
    bit rdy;
    int lo;
    #1;
    if (mdl_known) begin
      rdy = model_ready();
      check("s_ready", {63'd0, s_ready}, {63'd0, rdy});
      check("m_valid", {63'd0, m_valid}, {63'd0, mv});
      if (mv) begin
        check("m_task", m_task, mt);
        check("m_cq_slot", 64'(m_cq_slot), 64'(ms));
      end
      check("slots_in_use", 64'(slots_in_use), 64'(busy_count()));
      check("free_error", {63'd0, free_error}, {63'd0, merr});
    end else begin
      rdy = 1'b0;
    end
    if (!rstn) begin
      foreach (busy[i]) busy[i] = 1'b0;
      mv = 1'b0; merr = 1'b0; mdl_known = 1'b1;
    end else if (mdl_known) begin
      lo = lowest_free();
      if (free_valid) begin
        if (busy[int'(free_slot)]) busy[int'(free_slot)] = 1'b0;
        else merr = 1'b1;
      end
      if (s_valid && rdy) begin
        busy[lo] = 1'b1; mv = 1'b1; mt = s_task; ms = lo;
      end else if (m_ready) begin
        mv = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0; s_task = '0; m_ready = 1'b0; ser_almost_full = 1'b0;
    free_valid = 1'b0; free_slot = '0; slot_limit = 7'd64;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    cycle();
    cycle();
    rstn = 1'b1;
  endtask

  task automatic offer(input bit v, input bit rdy_out);
    s_valid = v;
    s_task  = {$urandom, $urandom};
    m_ready = rdy_out;
  endtask

  initial begin
    int q[$];
    @(negedge clk);
    do_reset();
    check("reset_in_use", 64'(slots_in_use), 64'd0);
    check("reset_m_valid", {63'd0, m_valid}, 64'd0);

    // A, B, C streamed with m_ready high.
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 1'b1);
      cycle();
      check("seq_slot", 64'(m_cq_slot), 64'(i));
    end
    offer(1'b0, 1'b1);
    check("seq_in_use", 64'(slots_in_use), 64'd3);
    cycle();

    // Hold A for 10 cycles with m_ready low, then release; B replaces it.
    do_reset();
    offer(1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 1'b0);
      cycle();
    end
    offer(1'b1, 1'b1);
    cycle();
    check("b2b_slot", 64'(m_cq_slot), 64'd1);

    // Fill all slots, release 17, expect reuse of 17.
    do_reset();
    for (int i = 0; i < N + 2; i++) begin
      offer(1'b1, 1'b1);
      cycle();
    end
    check("full_in_use", 64'(slots_in_use), 64'd64);
    check("full_ready", {63'd0, s_ready}, 64'd0);
    offer(1'b1, 1'b1);
    free_valid = 1'b1; free_slot = 6'd17;
    cycle();
    free_valid = 1'b0;
    check("freed_in_use", 64'(slots_in_use), 64'd63);
    offer(1'b1, 1'b1);
    cycle();
    check("reuse_slot", 64'(m_cq_slot), 64'd17);
    check("refill_in_use", 64'(slots_in_use), 64'd64);

    // Allocate 3, then free slot 1 while D is accepted.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 1'b1);
      cycle();
    end
    offer(1'b1, 1'b1);
    free_valid = 1'b1; free_slot = 6'd1;
    cycle();
    free_valid = 1'b0;
    check("d_slot", 64'(m_cq_slot), 64'd3);
    check("d_in_use", 64'(slots_in_use), 64'd3);

    // Double free of slot 40, then reset clears the flag.
    offer(1'b0, 1'b1);
    free_valid = 1'b1; free_slot = 6'd40;
    cycle();
    free_valid = 1'b0;
    cycle();
    check("dbl_free_err", {63'd0, free_error}, 64'd1);
    check("dbl_free_in_use", 64'(slots_in_use), 64'd3);
    do_reset();
    check("err_cleared", {63'd0, free_error}, 64'd0);

    // Slot limit stall, then almost-full still drains the held entry.
    slot_limit = 7'd2;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 1'b1);
      cycle();
    end
    check("limit_ready", {63'd0, s_ready}, 64'd0);
    check("limit_in_use", 64'(slots_in_use), 64'd2);
    do_reset();
    offer(1'b1, 1'b0);
    cycle();
    offer(1'b1, 1'b1);
    ser_almost_full = 1'b1;
    cycle();
    check("saf_drained", {63'd0, m_valid}, 64'd0);
    check("saf_in_use", 64'(slots_in_use), 64'd1);
    ser_almost_full = 1'b0;

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      offer(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60));
      ser_almost_full = ($urandom_range(0, 99) < 10);
      if (c % 200 == 0) slot_limit = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 64)) : 7'd64;
      q.delete();
      foreach (busy[i]) if (busy[i]) q.push_back(i);
      free_valid = ($urandom_range(0, 99) < 35);
      if (q.size() > 0 && $urandom_range(0, 99) < 97) free_slot = 6'(q[$urandom_range(0, q.size() - 1)]);
      else free_slot = 6'($urandom_range(0, N - 1));
      if (c % 1000 == 999) rstn = 1'b0;
      else rstn = 1'b1;
      cycle();
    end
    rstn = 1'b1;
    idle_inputs();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
